// File: rtl/ic_pkg.sv
// Shared icache types and constants for the tag-side logic.
// The tag entry layout is the tag RAM word, so it is packed.
package ic_pkg;

    localparam int LINES  = 256;
    localparam int LINE_W = $clog2(LINES);
    localparam int TAG_W  = 20;

    typedef logic [LINE_W-1:0] ic_line_t;
    typedef logic [TAG_W-1:0]  ic_tag_t;

    typedef struct packed {
        logic    valid;
        ic_tag_t tag;
    } ic_tag_entry_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } ic_tag_ctrl_state_t;

endpackage

// File: rtl/ic_sat_counter.sv
// Statistics counter that sticks at all-ones and clears on request.
// A clear takes priority over an increment in the same cycle.
module ic_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/ic_tag_ctrl.sv
// Icache tag RAM port owner: invalidate sweep, fetch lookups, refill writes
// and hit/miss statistics.
module ic_tag_ctrl
    import ic_pkg::*;
#(
    parameter bit FLUSH_ON_RESET = 1'b1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req,
    output logic             flush_busy,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  ic_line_t         lk_line,
    input  ic_tag_t          lk_tag,
    output logic             lk_resp_valid,
    output logic             lk_hit,
    input  logic             fill_valid,
    output logic             fill_ready,
    input  ic_line_t         fill_line,
    input  ic_tag_t          fill_tag,
    output logic             tr_rd_en,
    output ic_line_t         tr_rd_line,
    input  ic_tag_entry_t    tr_rd_data,
    output logic             tr_wr_en,
    output ic_line_t         tr_wr_line,
    output ic_tag_entry_t    tr_wr_data,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    ic_tag_ctrl_state_t state;
    ic_line_t           sw_idx;
    logic               vld_p1;
    ic_tag_t            lk_tag_p1;
    logic               run;
    logic               lk_acc;
    logic               fill_acc;
    logic               flush_acc;

    assign run        = rst_n && (state == RUN);
    assign flush_busy = (state == SWEEP);
    assign lk_ready   = run && !flush_req;
    assign fill_ready = run && !flush_req;
    assign lk_acc     = lk_valid && lk_ready;
    assign fill_acc   = fill_valid && fill_ready;
    assign flush_acc  = run && flush_req;

    // Stage p0: tag RAM request (read for lookup, write for sweep or fill)
    assign tr_rd_en   = lk_acc;
    assign tr_rd_line = lk_line;

    always_comb begin
        tr_wr_en         = 1'b0;
        tr_wr_line       = fill_line;
        tr_wr_data.valid = 1'b1;
        tr_wr_data.tag   = fill_tag;
        if (rst_n && (state == SWEEP)) begin
            tr_wr_en   = 1'b1;
            tr_wr_line = sw_idx;
            tr_wr_data = '0;
        end else if (fill_acc) begin
            tr_wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (FLUSH_ON_RESET) begin
                state <= SWEEP;
            end else begin
                state <= RUN;
            end
            sw_idx <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= lk_acc;
            case (state)
                SWEEP: begin
                    sw_idx <= sw_idx + 1'b1;
                    if (sw_idx == ic_line_t'(LINES - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush_req) begin
                        state  <= SWEEP;
                        sw_idx <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (lk_acc) begin
            lk_tag_p1 <= lk_tag;
        end
    end

    // Stage p1: RAM data returns, compare against the held tag
    assign lk_resp_valid = vld_p1;
    assign lk_hit        = vld_p1 && tr_rd_data.valid && (tr_rd_data.tag == lk_tag_p1);

    ic_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (vld_p1 && lk_hit),
        .clr   (flush_acc),
        .cnt   (hit_cnt)
    );

    ic_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (vld_p1 && !lk_hit),
        .clr   (flush_acc),
        .cnt   (miss_cnt)
    );

endmodule

// File: tb/tb_ic_tag_ctrl.sv
// Bench for ic_tag_ctrl with a write-first registered tag RAM model and a
// response scoreboard; narrow counters so saturation is reachable.
module tb_ic_tag_ctrl;
    import ic_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_req = 1'b0;
    logic          flush_busy;
    logic          lk_valid = 1'b0;
    logic          lk_ready;
    ic_line_t      lk_line = '0;
    ic_tag_t       lk_tag = '0;
    logic          lk_resp_valid;
    logic          lk_hit;
    logic          fill_valid = 1'b0;
    logic          fill_ready;
    ic_line_t      fill_line = '0;
    ic_tag_t       fill_tag = '0;
    logic          tr_rd_en;
    ic_line_t      tr_rd_line;
    ic_tag_entry_t tr_rd_data;
    logic          tr_wr_en;
    ic_line_t      tr_wr_line;
    ic_tag_entry_t tr_wr_data;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    ic_tag_ctrl #(.FLUSH_ON_RESET(1'b1), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
        .lk_valid      (lk_valid),
        .lk_ready      (lk_ready),
        .lk_line       (lk_line),
        .lk_tag        (lk_tag),
        .lk_resp_valid (lk_resp_valid),
        .lk_hit        (lk_hit),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_line     (fill_line),
        .fill_tag      (fill_tag),
        .tr_rd_en      (tr_rd_en),
        .tr_rd_line    (tr_rd_line),
        .tr_rd_data    (tr_rd_data),
        .tr_wr_en      (tr_wr_en),
        .tr_wr_line    (tr_wr_line),
        .tr_wr_data    (tr_wr_data),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    // Tag RAM: starts full of valid entries with tag 0x3A5 so a missed sweep shows up as hits
    ic_tag_entry_t mem [LINES];
    bit            ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < LINES; i++) mem[i] <= {1'b1, 20'h003A5};
            tr_rd_data <= '0;
            ram_init   <= 1'b1;
        end else begin
            if (tr_rd_en)
                tr_rd_data <= (tr_wr_en && tr_wr_line == tr_rd_line) ? tr_wr_data : mem[tr_rd_line];
            if (tr_wr_en)
                mem[tr_wr_line] <= tr_wr_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit e;
        if (rst_n && lk_resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lk_resp_unexpected: got response hit=%0b expected none", lk_hit);
            end else begin
                e = exp_q.pop_front();
                check("lk_hit", lk_hit, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int inject_at);
        int idx = 0;
        int bad = 0;
        while (flush_busy && idx < LINES + 20) begin
            if (!(tr_wr_en && tr_wr_line == ic_line_t'(idx) && !tr_wr_data.valid &&
                  tr_wr_data.tag == '0 && !lk_ready && !fill_ready))
                bad++;
            flush_req = (idx == inject_at);
            idx++;
            step();
            flush_req = 1'b0;
        end
        flush_req = 1'b0;
        #1;
        check("sweep_len", idx, LINES);
        check("sweep_writes_bad", bad, 0);
        check("ready_after_sweep", lk_ready, 1'b1);
    endtask

    task automatic issue(input bit do_fill, input ic_line_t fl, input ic_tag_t ft,
                         input bit do_lk, input ic_line_t ll, input ic_tag_t lt, input bit exp);
        fill_valid = do_fill; fill_line = fl; fill_tag = ft;
        lk_valid = do_lk; lk_line = ll; lk_tag = lt;
        #1;
        if (do_fill) begin
            check("fill_ready", fill_ready, 1'b1);
            check("fill_wr_en", tr_wr_en, 1'b1);
            check("fill_wr_line", tr_wr_line, fl);
            check("fill_wr_data", tr_wr_data, {1'b1, ft});
        end
        if (do_lk) begin
            check("lk_ready", lk_ready, 1'b1);
            check("lk_rd_en", tr_rd_en, 1'b1);
            check("lk_rd_line", tr_rd_line, ll);
            exp_q.push_back(exp);
        end
        step();
        fill_valid = 1'b0;
        lk_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) step();
        check("rst_resp_valid", lk_resp_valid, 1'b0);
        check("rst_lk_hit", lk_hit, 1'b0);
        check("rst_rd_en", tr_rd_en, 1'b0);
        check("rst_wr_en", tr_wr_en, 1'b0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("busy_after_reset", flush_busy, 1'b1);
        sweep(-1);

        // Fill then hit and miss lookups back to back
        issue(1, 8'h12, 20'h003A5, 0, '0, '0, 0);
        issue(0, '0, '0, 1, 8'h12, 20'h003A5, 1);
        issue(0, '0, '0, 1, 8'h12, 20'h003A4, 0);
        repeat (2) step();
        check("hit_cnt_a", hit_cnt, 1);
        check("miss_cnt_a", miss_cnt, 1);

        // Same-cycle fill and lookup on one line; then a swept (invalid) line with tag 0
        issue(1, 8'h40, 20'h00111, 1, 8'h40, 20'h00111, 1);
        issue(0, '0, '0, 1, 8'h41, 20'h00000, 0);
        repeat (2) step();
        check("hit_cnt_b", hit_cnt, 2);
        check("miss_cnt_b", miss_cnt, 2);

        // Lookup then flush on the next cycle
        issue(0, '0, '0, 1, 8'h12, 20'h003A5, 1);
        flush_req = 1'b1;
        #1;
        check("lk_ready_flush_req", lk_ready, 1'b0);
        step();
        flush_req = 1'b0;
        check("hit_cnt_flush_clr", hit_cnt, 0);
        check("miss_cnt_flush_clr", miss_cnt, 0);
        sweep(-1);
        issue(0, '0, '0, 1, 8'h12, 20'h003A5, 0);
        repeat (2) step();
        check("miss_cnt_after_flush", miss_cnt, 1);
        check("hit_cnt_after_flush", hit_cnt, 0);

        // Flush request mid-sweep is ignored
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        sweep(100);

        // Reset in the middle of a sweep restarts from line 0
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        sweep(-1);

        // Saturation of the hit counter
        issue(1, 8'h05, 20'h00077, 0, '0, '0, 0);
        for (int i = 0; i < 14; i++) issue(0, '0, '0, 1, 8'h05, 20'h00077, 1);
        repeat (2) step();
        check("hit_cnt_14", hit_cnt, 14);
        for (int i = 0; i < 3; i++) issue(0, '0, '0, 1, 8'h05, 20'h00077, 1);
        repeat (2) step();
        check("hit_cnt_sat", hit_cnt, 15);
        check("miss_cnt_sat", miss_cnt, 0);

        repeat (2) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
